// File: rtl/neural_network_layer1.sv
// Two-neuron fixed-point dense layer with ReLU, sequenced one MAC per
// cycle and handshaked with req / ack__layer.
module neural_network_layer1 #(
  parameter int FRAC_BITS = 4,
  parameter logic signed [7:0] W00 = 8'sd16,
  parameter logic signed [7:0] W01 = -8'sd8,
  parameter logic signed [7:0] W10 = 8'sd24,
  parameter logic signed [7:0] W11 = 8'sd32,
  parameter logic signed [7:0] B0 = 8'sd4,
  parameter logic signed [7:0] B1 = -8'sd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic signed [7:0] a0,
  input  logic signed [7:0] a1,
  output logic              ack__layer,
  output logic signed [7:0] y0,
  output logic signed [7:0] y1,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    BIAS,
    ACT,
    DONE
  } state_t;

  state_t state;

  logic signed [7:0]  x0;
  logic signed [7:0]  x1;
  logic signed [7:0]  acc0;
  logic signed [7:0]  acc1;
  logic [1:0]         step;
  logic signed [7:0]  w_sel;
  logic signed [7:0]  x_sel;
  logic signed [15:0] w_ext;
  logic signed [15:0] x_ext;
  logic signed [15:0] prod;
  logic signed [7:0]  term;

  always_comb begin
    w_sel = '0;
    x_sel = '0;
    unique case (step)
      2'd0: begin w_sel = W00; x_sel = x0; end
      2'd1: begin w_sel = W01; x_sel = x1; end
      2'd2: begin w_sel = W10; x_sel = x0; end
      2'd3: begin w_sel = W11; x_sel = x1; end
    endcase
  end

  // Full-width product, floor shift, then keep the low byte (wraps).
  assign w_ext = {{8{w_sel[7]}}, w_sel};
  assign x_ext = {{8{x_sel[7]}}, x_sel};
  assign prod  = w_ext * x_ext;
  assign term  = 8'(prod >>> FRAC_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x0         <= '0;
      x1         <= '0;
      acc0       <= '0;
      acc1       <= '0;
      step       <= '0;
      y0         <= '0;
      y1         <= '0;
      ack__layer <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            x0    <= a0;
            x1    <= a1;
            acc0  <= '0;
            acc1  <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          if (step[1]) acc1 <= acc1 + term;
          else         acc0 <= acc0 + term;
          step <= step + 2'd1;
          if (step == 2'd3) state <= BIAS;
        end
        BIAS: begin
          acc0  <= acc0 + B0;
          acc1  <= acc1 + B1;
          state <= ACT;
        end
        ACT: begin
          y0         <= acc0[7] ? 8'sd0 : acc0;
          y1         <= acc1[7] ? 8'sd0 : acc1;
          ack__layer <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          // Hold the result until upstream drops req.
          if (!req) begin
            ack__layer <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_network_layer1.sv
// Scoreboard bench for neural_network_layer1: directed vectors,
// monitor pops expected results on each rising ack__layer.
module tb_neural_network_layer1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic signed [7:0] a0 = '0;
  logic signed [7:0] a1 = '0;
  logic              ack__layer;
  logic signed [7:0] y0;
  logic signed [7:0] y1;
  logic              busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] sb[$];
  logic        ack_prev = 1'b0;

  neural_network_layer1 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a0         (a0),
    .a1         (a1),
    .ack__layer (ack__layer),
    .y0         (y0),
    .y1         (y1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack__layer && !ack_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("sb_y0", int'(y0), int'($signed(e[15:8])));
        check("sb_y1", int'(y1), int'($signed(e[7:0])));
      end
    end
    ack_prev = ack__layer;
  end

  task automatic run(input logic signed [7:0] x0, input logic signed [7:0] x1,
                     input logic signed [7:0] e0, input logic signed [7:0] e1,
                     input bit perturb, input int hold);
    int cnt;
    @(negedge clk);
    a0 = x0;
    a1 = x1;
    req = 1'b1;
    sb.push_back({e0, e1});
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
      if (perturb && cnt == 1) begin
        a0 = -8'sd128;
        a1 = -8'sd128;
      end
      if (cnt == 2) check("busy_mac", int'(busy), 1);
    end while (!ack__layer && cnt < 20);
    check("latency", cnt, 7);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ack", int'(ack__layer), 1);
      check("hold_y0", int'(y0), int'(e0));
      check("hold_y1", int'(y1), int'(e1));
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("ack_clear", int'(ack__layer), 0);
    check("busy_clear", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", int'(ack__layer), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_y0", int'(y0), 0);
    check("rst_y1", int'(y1), 0);
    @(negedge clk);
    rst = 1'b0;

    run(8'sd32, 8'sd16, 8'sd28, 8'sd64, 1'b0, 0);
    run(-8'sd32, 8'sd0, 8'sd0, 8'sd0, 1'b0, 0);
    run(8'sd127, 8'sd127, 8'sd67, 8'sd0, 1'b0, 0);
    run(8'sd1, 8'sd1, 8'sd4, 8'sd0, 1'b0, 0);
    // req held ~20 cycles total: 7 to ack plus 13 held in DONE
    run(8'sd32, 8'sd16, 8'sd28, 8'sd64, 1'b0, 13);
    run(8'sd48, 8'sd16, 8'sd44, 8'sd88, 1'b0, 0);

    // Abort mid-MAC; no result is queued for it.
    @(negedge clk);
    a0 = 8'sd127;
    a1 = 8'sd127;
    req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ack", int'(ack__layer), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_y0", int'(y0), 0);
    check("abort_y1", int'(y1), 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'sd32, 8'sd16, 8'sd28, 8'sd64, 1'b0, 0);

    run(8'sd48, 8'sd16, 8'sd44, 8'sd88, 1'b1, 2);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
